trivium_out_fifo: RTL and testbench
===================================

# trivium_out_fifo

Output buffer directly downstream of the Trivium keystream core. It captures each encrypted byte the core presents on `stream` (qualified by `wt_sgn`) into a byte-wide circular buffer and hands bytes to the consumer through a registered read port. It reports occupancy back to the core on `fifo_cnd`; the core leaves its `Secret_Ready` state only when `fifo_cnd == 2'b00` (buffer drained).

## Interface
- `DEPTH_LOG2`, default 8: buffer depth is 2^DEPTH_LOG2 bytes. The default of 256 holds one full 256-byte core burst.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `wr_data` in 8: encrypted byte, connected to the core's `stream`.
- `wr_en` in 1: write strobe, connected to the core's `wt_sgn`.
- `rd_en` in 1: consumer read request.
- `flush` in 1: synchronous clear of contents and the overflow flag.
- `rd_data` out 8: read byte, registered.
- `rd_valid` out 1: `rd_data` is valid this cycle (one-cycle pulse per accepted read).
- `fifo_cnd` out 2: status to the core. `00` = empty, `01` = partial, `10` = full, `11` = overflow (sticky).
- `level` out DEPTH_LOG2+1: current occupancy, 0 to 2^DEPTH_LOG2.
- `burst_done` out 1: one-cycle pulse when the buffer goes from non-empty to empty because of a read.

## Operation
- Storage is a 2^DEPTH_LOG2 x 8 array with write pointer `wp` and read pointer `rp`, each DEPTH_LOG2 bits. Pointers wrap modulo the depth.
- `level` is a separate DEPTH_LOG2+1 bit counter. It never exceeds the depth and never goes below 0.
- Write accept: `wr_en && level != DEPTH` at the clock edge. The byte is stored at `wp`, `wp` increments, and `level` increments.
- Write while full and no read in the same cycle: the byte is dropped and the overflow flag `ovf` is set. `ovf` is sticky and clears only on `flush` or `rst`.
- Read accept: `rd_en && level != 0`. `mem[rp]` is registered into `rd_data`, `rd_valid` is set to 1, and `rp` increments.
- Read while empty: ignored. `rd_valid` stays 0 and `rd_data` holds its previous value.
- Simultaneous write and read:
  - At full: both are accepted and `level` is unchanged. No overflow.
  - At empty: only the write is accepted. There is no fall-through; the byte becomes readable from the next cycle.
  - Otherwise: both are accepted and `level` is unchanged.
- `fifo_cnd` priority: `ovf` gives `11`; else `level == 0` gives `00`; else `level == DEPTH` gives `10`; else `01`.
- `flush` has priority over same-cycle reads and writes. It zeroes `wp`, `rp`, `level` and `ovf`, and forces `rd_valid` to 0. Array contents are left as they are.
- `burst_done` is 1 for one cycle when a read takes `level` from 1 to 0. It does not pulse on `flush`.
- Read-side state machine:
  - `EMPTY`: go to `FILL` on an accepted write.
  - `FILL`: go to `FULL` when `level` reaches DEPTH; go to `EMPTY` when it reaches 0.
  - `FULL`: go to `FILL` on an accepted read without a write; go to `OVF` on a dropped write.
  - `OVF`: go to `EMPTY` on `flush`.
  - `fifo_cnd` equals the state encoding.

## Timing
- Reset values: `rd_data = 0`, `rd_valid = 0`, `fifo_cnd = 00`, `level = 0`, `burst_done = 0`. Pointers, `ovf` and state are also cleared, with state = `EMPTY`.
- `rst` asserted mid-burst discards all contents immediately (asynchronous).
- Write-to-status latency: `level` and `fifo_cnd` update on the edge that accepts the write.
- Read latency: `rd_data` and `rd_valid` appear 1 cycle after the `rd_en` edge.
- Back-to-back reads every cycle give one byte per cycle.
- All outputs are registered or decoded only from registered state. There is no combinational path from any input to any output.

## Configuration
- `TRIVIUM_FIFO_PARITY_EN` defined:
  - Each entry stores 9 bits: the byte plus even parity computed at write.
  - An extra output `rd_perr` (1 bit, reset 0) is registered with `rd_data`. It is 1 when the stored parity mismatches the read byte.
- Not defined: entries are 8 bits and `rd_perr` does not exist.

## Test plan
- Reset, then write 0xA5 and read it: `fifo_cnd` goes `00` → `01` → `00`; `rd_data = 0xA5` with `rd_valid = 1` one cycle after `rd_en`; `burst_done` pulses once.
- Write 256 bytes 0x00..0xFF, then read 256 times: `level = 256` and `fifo_cnd = 10` after the last write; reads return 0x00..0xFF in order; `fifo_cnd = 00` at the end.
- Fill to 256, then write 0x3C without a read: `fifo_cnd = 11` and `level = 256`. Drain all bytes: 0x3C never appears and `fifo_cnd` stays `11`. `flush`: `fifo_cnd = 00`, `level = 0`.
- Fill to 256, then assert `wr_en` and `rd_en` in the same cycle with 0x77: `level` stays 256, there is no overflow, and 0x77 is the last byte read out.
- Empty buffer, `wr_en` and `rd_en` together with 0x11: `rd_valid = 0` that cycle and `level = 1`; the next read returns 0x11.
- Write 10 bytes, drop `rst` low for one cycle mid-write: all outputs return to their reset values immediately and the next read request gives `rd_valid = 0`. With `TRIVIUM_FIFO_PARITY_EN` defined, forcing a stored bit flip gives `rd_perr = 1`.

Source files
------------

// File: rtl/trivium_out_fifo.sv
// Byte-wide circular output buffer behind the Trivium keystream core, with registered read port and occupancy status.
// Optional: define TRIVIUM_FIFO_PARITY_EN to store even parity per entry and report rd_perr on reads.
module trivium_out_fifo #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  flush,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  output logic [1:0]            fifo_cnd,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  burst_done
`ifdef TRIVIUM_FIFO_PARITY_EN
  ,
  output logic                  rd_perr
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);

`ifdef TRIVIUM_FIFO_PARITY_EN
  localparam int ENTRY_W = 9;
`else
  localparam int ENTRY_W = 8;
`endif

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] FILL  = 2'b01;
  localparam logic [1:0] FULL  = 2'b10;
  localparam logic [1:0] OVF   = 2'b11;

  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wp_q, wp_d;
  logic [DEPTH_LOG2-1:0] rp_q, rp_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [1:0]            state_q, state_d;
  logic [7:0]            rd_data_q;
  logic                  rd_valid_q;
  logic                  burst_done_q;
  logic                  is_empty, is_full;
  logic                  rd_acc, wr_acc, wr_drop;
  logic [ENTRY_W-1:0]    wr_entry;
  logic [ENTRY_W-1:0]    rd_entry;

  assign is_empty = (level_q == '0);
  assign is_full  = (level_q == LEVEL_FULL);

  // A read frees a slot in the same edge, so a write at full is only dropped when no read accompanies it.
  assign rd_acc  = rd_en && !is_empty && !flush;
  assign wr_acc  = wr_en && !flush && (!is_full || rd_acc);
  assign wr_drop = wr_en && !flush && is_full && !rd_acc;

`ifdef TRIVIUM_FIFO_PARITY_EN
  assign wr_entry = {^wr_data, wr_data};
`else
  assign wr_entry = wr_data;
`endif
  assign rd_entry = mem[rp_q];

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      level_d = '0;
    end else begin
      if (wr_acc) wp_d = wp_q + 1'b1;
      if (rd_acc) rp_d = rp_q + 1'b1;
      if (wr_acc && !rd_acc)      level_d = level_q + 1'b1;
      else if (rd_acc && !wr_acc) level_d = level_q - 1'b1;
    end
  end

  // The OVF state doubles as the sticky overflow flag; only flush or reset leave it.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (wr_acc) state_d = (level_d == LEVEL_FULL) ? FULL : FILL;
        FILL: begin
          if (level_d == LEVEL_FULL) state_d = FULL;
          else if (level_d == '0)    state_d = EMPTY;
        end
        FULL: begin
          if (wr_drop)               state_d = OVF;
          else if (rd_acc && !wr_acc) state_d = (level_d == '0) ? EMPTY : FILL;
        end
        default: state_d = OVF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q         <= '0;
      rp_q         <= '0;
      level_q      <= '0;
      state_q      <= EMPTY;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      level_q      <= level_d;
      state_q      <= state_d;
      rd_valid_q   <= rd_acc;
      burst_done_q <= rd_acc && !wr_acc && (level_q == LEVEL_ONE);
      if (rd_acc) rd_data_q <= rd_entry[7:0];
    end
  end

  // Storage has no reset; stale contents are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wp_q] <= wr_entry;
  end

`ifdef TRIVIUM_FIFO_PARITY_EN
  logic rd_perr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_perr_q <= 1'b0;
    end else if (rd_acc) begin
      rd_perr_q <= rd_entry[8] ^ (^rd_entry[7:0]);
    end
  end

  assign rd_perr = rd_perr_q;
`endif

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign fifo_cnd   = state_q;
  assign level      = level_q;
  assign burst_done = burst_done_q;

endmodule

// File: tb/tb_trivium_out_fifo.sv
// Self-checking bench for trivium_out_fifo: directed scenarios plus randomized traffic against a queue model.
module tb_trivium_out_fifo;

  localparam int DL    = 8;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    wr_data = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          flush = 1'b0;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [1:0]    fifo_cnd;
  logic [DL:0]   level;
  logic          burst_done;
`ifdef TRIVIUM_FIFO_PARITY_EN
  logic          rd_perr;
`endif

  trivium_out_fifo #(.DEPTH_LOG2(DL)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .flush      (flush),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fifo_cnd   (fifo_cnd),
    .level      (level),
    .burst_done (burst_done)
`ifdef TRIVIUM_FIFO_PARITY_EN
    ,
    .rd_perr    (rd_perr)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: contents as a queue, a sticky overflow bit and the expected read-port outputs.
  byte unsigned q[$];
  bit           ovfM;
  logic [7:0]   expData;
  bit           expValid;
  bit           expBurst;

  function automatic logic [1:0] expCnd();
    if (ovfM)              return 2'b11;
    if (q.size() == 0)     return 2'b00;
    if (q.size() == DEPTH) return 2'b10;
    return 2'b01;
  endfunction

  function automatic logic [DL:0] expLevel();
    return (DL + 1)'(q.size());
  endfunction

  task automatic modelReset();
    q.delete();
    ovfM     = 1'b0;
    expData  = 8'h00;
    expValid = 1'b0;
    expBurst = 1'b0;
  endtask

  // Drive one cycle of inputs, let the edge happen, then advance the model.
  task automatic cycle(input bit we, input logic [7:0] wd, input bit re, input bit fl);
    bit rdOk, wrOk;
    int sz;
    @(negedge clk);
    wr_en = we; wr_data = wd; rd_en = re; flush = fl;
    @(posedge clk);
    #1;
    sz = q.size();
    if (fl) begin
      q.delete();
      ovfM     = 1'b0;
      expValid = 1'b0;
      expBurst = 1'b0;
    end else begin
      rdOk = re && (sz > 0);
      wrOk = we && ((sz < DEPTH) || rdOk);
      expValid = rdOk;
      expBurst = rdOk && !wrOk && (sz == 1);
      if (rdOk) expData = q.pop_front();
      if (wrOk) q.push_back(wd);
      if (we && !wrOk) ovfM = 1'b1;
    end
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    modelReset();
    #1;
    total++; if (rd_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_rd_data got=%h want=00", rd_data); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rd_valid got=%b want=0", rd_valid); end
    total++; if (fifo_cnd !== 2'b00) begin bad++; $display("[TB] FAIL reset_fifo_cnd got=%b want=00", fifo_cnd); end
    total++; if (level !== '0) begin bad++; $display("[TB] FAIL reset_level got=%0d want=0", level); end
    total++; if (burst_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_burst_done got=%b want=0", burst_done); end
  endtask

  task automatic test_single();
    int pulses = 0;
    cycle(1, 8'hA5, 0, 0);
    total++; if (fifo_cnd !== 2'b01) begin bad++; $display("[TB] FAIL single_cnd_after_write got=%b want=01", fifo_cnd); end
    cycle(0, 8'h00, 1, 0);
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin bad++; $display("[TB] FAIL single_read got=%b/%h want=1/a5", rd_valid, rd_data); end
    total++; if (fifo_cnd !== 2'b00) begin bad++; $display("[TB] FAIL single_cnd_after_read got=%b want=00", fifo_cnd); end
    if (burst_done === 1'b1) pulses++;
    cycle(0, 8'h00, 0, 0);
    if (burst_done === 1'b1) pulses++;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_valid_pulse got=%b want=0", rd_valid); end
    total++; if (pulses != 1) begin bad++; $display("[TB] FAIL single_burst_pulses got=%0d want=1", pulses); end
  endtask

  task automatic test_fill_drain();
    int errs = 0;
    for (int i = 0; i < DEPTH; i++) cycle(1, 8'(i), 0, 0);
    total++; if (level !== 9'd256 || fifo_cnd !== 2'b10) begin bad++; $display("[TB] FAIL fill_full got=%0d/%b want=256/10", level, fifo_cnd); end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 8'h00, 1, 0);
      if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
        errs++;
        $display("[TB] FAIL drain_order idx=%0d got=%b/%h want=1/%h", i, rd_valid, rd_data, 8'(i));
      end
    end
    total++; if (errs != 0) bad++;
    total++; if (fifo_cnd !== 2'b00 || burst_done !== 1'b1) begin bad++; $display("[TB] FAIL drain_end got=%b/%b want=00/1", fifo_cnd, burst_done); end
  endtask

  task automatic test_overflow();
    int seen3c = 0;
    int cndErr = 0;
    for (int i = 0; i < DEPTH; i++) cycle(1, (i == 8'h3C) ? 8'h00 : 8'(i), 0, 0);
    cycle(1, 8'h3C, 0, 0);
    total++; if (fifo_cnd !== 2'b11 || level !== 9'd256) begin bad++; $display("[TB] FAIL ovf_set got=%b/%0d want=11/256", fifo_cnd, level); end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 8'h00, 1, 0);
      if (rd_data === 8'h3C) seen3c++;
      if (fifo_cnd !== 2'b11) cndErr++;
    end
    total++; if (seen3c != 0) begin bad++; $display("[TB] FAIL ovf_dropped_byte seen=%0d want=0", seen3c); end
    total++; if (cndErr != 0) begin bad++; $display("[TB] FAIL ovf_sticky wrong_cycles=%0d want=0", cndErr); end
    cycle(0, 8'h00, 0, 1);
    total++; if (fifo_cnd !== 2'b00 || level !== '0) begin bad++; $display("[TB] FAIL ovf_flush got=%b/%0d want=00/0", fifo_cnd, level); end
  endtask

  task automatic test_full_simul();
    logic [7:0] last;
    for (int i = 0; i < DEPTH; i++) cycle(1, 8'(i + 1), 0, 0);
    cycle(1, 8'h77, 1, 0);
    total++; if (level !== 9'd256 || fifo_cnd !== 2'b10) begin bad++; $display("[TB] FAIL full_simul got=%0d/%b want=256/10", level, fifo_cnd); end
    total++; if (rd_data !== 8'h01) begin bad++; $display("[TB] FAIL full_simul_first got=%h want=01", rd_data); end
    last = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 8'h00, 1, 0);
      last = rd_data;
    end
    total++; if (last !== 8'h77) begin bad++; $display("[TB] FAIL full_simul_last got=%h want=77", last); end
  endtask

  task automatic test_empty_simul();
    cycle(1, 8'h11, 1, 0);
    total++; if (rd_valid !== 1'b0 || level !== 9'd1) begin bad++; $display("[TB] FAIL empty_simul got=%b/%0d want=0/1", rd_valid, level); end
    cycle(0, 8'h00, 1, 0);
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'h11) begin bad++; $display("[TB] FAIL empty_simul_read got=%b/%h want=1/11", rd_valid, rd_data); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 10; i++) cycle(1, 8'(8'hC0 + i), 0, 0);
    cycle(0, 8'h00, 1, 0);
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'hEE;
    #1 rst = 1'b0;
    #1;
    total++; if (level !== '0 || fifo_cnd !== 2'b00 || rd_valid !== 1'b0 || rd_data !== 8'h00 || burst_done !== 1'b0) begin
      bad++; $display("[TB] FAIL async_reset got=%0d/%b/%b/%h/%b want=0/00/0/00/0", level, fifo_cnd, rd_valid, rd_data, burst_done);
    end
    @(negedge clk);
    wr_en = 1'b0;
    rst = 1'b1;
    modelReset();
    cycle(0, 8'h00, 1, 0);
    total++; if (rd_valid !== 1'b0 || level !== '0) begin bad++; $display("[TB] FAIL async_reset_read got=%b/%0d want=0/0", rd_valid, level); end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int n = 0; n < 3000; n++) begin
      int phase = (n / 500) % 2;
      bit we = ($urandom_range(99) < (phase == 0 ? 85 : 30));
      bit re = ($urandom_range(99) < (phase == 0 ? 20 : 80));
      bit fl = ($urandom_range(299) == 0);
      cycle(we, 8'($urandom), re, fl);
      if (level !== expLevel() || fifo_cnd !== expCnd() || rd_valid !== expValid ||
          rd_data !== expData || burst_done !== expBurst) begin
        errs++;
        $display("[TB] FAIL random n=%0d got lvl=%0d cnd=%b v=%b d=%h b=%b want lvl=%0d cnd=%b v=%b d=%h b=%b",
                 n, level, fifo_cnd, rd_valid, rd_data, burst_done,
                 expLevel(), expCnd(), expValid, expData, expBurst);
      end
    end
    total++; if (errs != 0) bad++;
  endtask

`ifdef TRIVIUM_FIFO_PARITY_EN
  task automatic test_parity();
    cycle(0, 8'h00, 0, 1);
    cycle(1, 8'h5A, 0, 0);
    cycle(1, 8'h3B, 0, 0);
    cycle(0, 8'h00, 1, 0);
    total++; if (rd_perr !== 1'b0) begin bad++; $display("[TB] FAIL parity_clean got=%b want=0", rd_perr); end
    dut.mem[1] = dut.mem[1] ^ 9'h004;
    cycle(0, 8'h00, 1, 0);
    total++; if (rd_perr !== 1'b1) begin bad++; $display("[TB] FAIL parity_flip got=%b want=1", rd_perr); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_overflow();
    test_full_simul();
    test_empty_simul();
    test_async_reset();
`ifdef TRIVIUM_FIFO_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
